// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-path defaults and packet/prediction types
package fetch_pkg;

    localparam int XLEN_DEF        = 64;
    localparam int INST_W_DEF      = 32;
    localparam int FETCH_WIDTH_DEF = 2;
    localparam int SEL_W_DEF       = $clog2(FETCH_WIDTH_DEF);
    localparam int BR_TYPE_W       = 4;

    typedef struct packed {
        logic                   valid;
        logic [XLEN_DEF-1:0]    target;
        logic [BR_TYPE_W-1:0]   branch_type;
        logic [SEL_W_DEF-1:0]   select;
        logic                   taken;
    } bp_pack_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0]                   pc;
        logic [FETCH_WIDTH_DEF-1:0]            valids;
        logic [FETCH_WIDTH_DEF*INST_W_DEF-1:0] insts;
        bp_pack_t                              bp;
    } fetch_packet_t;

endpackage

// File: rtl/fetch_mask_gen.sv
// rtl/fetch_mask_gen.sv - block-aligned PC and per-slot valid mask for a fetch block
module fetch_mask_gen
    import fetch_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
    parameter int INST_W      = INST_W_DEF,
    localparam int SEL_W      = $clog2(FETCH_WIDTH)
) (
    input  logic [XLEN-1:0]        pc_i,
    input  logic                   bp_valid_i,
    input  logic                   bp_taken_i,
    input  logic [SEL_W-1:0]       bp_select_i,
    output logic [XLEN-1:0]        pc_aligned_o,
    output logic [FETCH_WIDTH-1:0] mask_o
);

    localparam int OFF = $clog2(FETCH_WIDTH * INST_W / 8);
    localparam logic [XLEN-1:0] OFF_MASK = (XLEN'(1) << OFF) - XLEN'(1);

    logic [SEL_W-1:0] start_slot;
    logic [SEL_W-1:0] slot;
    logic             cut_at_branch;

    assign pc_aligned_o  = pc_i & ~OFF_MASK;
    assign start_slot    = pc_i[2 +: SEL_W];
    assign cut_at_branch = bp_valid_i & bp_taken_i;

    // Slots before the entry point or after a taken branch carry no useful instruction.
    always_comb begin
        mask_o = '0;
        slot   = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            slot      = SEL_W'(k);
            mask_o[k] = (slot >= start_slot) && !(cut_at_branch && (slot > bp_select_i));
        end
    end

endmodule

// File: rtl/fetch_res_queue.sv
// rtl/fetch_res_queue.sv - formats fetch blocks into packets and buffers them for decode
module fetch_res_queue
    import fetch_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
    parameter int INST_W      = INST_W_DEF,
    parameter int DEPTH       = 4,
    localparam int SEL_W      = $clog2(FETCH_WIDTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_i_valid,
    output logic                          io_i_ready,
    input  logic [XLEN-1:0]               io_i_pc,
    input  logic [FETCH_WIDTH*INST_W-1:0] io_i_fetch_res,
    input  logic                          io_i_stall,
    input  logic                          io_i_flush,
    input  logic                          io_i_bp_valid,
    input  logic                          io_i_bp_taken,
    input  logic [XLEN-1:0]               io_i_bp_target,
    input  logic [3:0]                    io_i_bp_branch_type,
    input  logic [SEL_W-1:0]              io_i_bp_select,
    output logic                          io_o_valid,
    input  logic                          io_o_ready,
    output logic [XLEN-1:0]               io_o_pc,
    output logic [FETCH_WIDTH-1:0]        io_o_valids,
    output logic [FETCH_WIDTH*INST_W-1:0] io_o_insts,
    output logic                          io_o_bp_valid,
    output logic [XLEN-1:0]               io_o_bp_target,
    output logic [3:0]                    io_o_bp_branch_type,
    output logic [SEL_W-1:0]              io_o_bp_select,
    output logic                          io_o_bp_taken
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0]               pc;
        logic [FETCH_WIDTH-1:0]        valids;
        logic [FETCH_WIDTH*INST_W-1:0] insts;
        logic                          bp_valid;
        logic [XLEN-1:0]               bp_target;
        logic [3:0]                    bp_branch_type;
        logic [SEL_W-1:0]              bp_select;
        logic                          bp_taken;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            wr_entry;
    entry_t            head_entry;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [XLEN-1:0]   pc_aligned;
    logic [FETCH_WIDTH-1:0] mask;
    logic              enq;
    logic              deq;

    fetch_mask_gen #(
        .XLEN        (XLEN),
        .FETCH_WIDTH (FETCH_WIDTH),
        .INST_W      (INST_W)
    ) u_mask_gen (
        .pc_i         (io_i_pc),
        .bp_valid_i   (io_i_bp_valid),
        .bp_taken_i   (io_i_bp_taken),
        .bp_select_i  (io_i_bp_select),
        .pc_aligned_o (pc_aligned),
        .mask_o       (mask)
    );

    // A full queue refuses input even if the head leaves this cycle; flush blocks both sides.
    assign io_i_ready = (count_q < CNT_W'(DEPTH)) & ~io_i_flush;
    assign io_o_valid = (count_q != '0) & ~io_i_flush;
    // Fully masked blocks are accepted but never occupy an entry.
    assign enq        = io_i_valid & io_i_ready & ~io_i_stall & (|mask);
    assign deq        = io_o_valid & io_o_ready;

    assign wr_entry = '{
        pc:             pc_aligned,
        valids:         mask,
        insts:          io_i_fetch_res,
        bp_valid:       io_i_bp_valid,
        bp_target:      io_i_bp_target,
        bp_branch_type: io_i_bp_branch_type,
        bp_select:      io_i_bp_select,
        bp_taken:       io_i_bp_taken
    };

    assign head_entry          = mem_q[head_q];
    assign io_o_pc             = head_entry.pc;
    assign io_o_valids         = head_entry.valids & {FETCH_WIDTH{io_o_valid}};
    assign io_o_insts          = head_entry.insts;
    assign io_o_bp_valid       = head_entry.bp_valid;
    assign io_o_bp_target      = head_entry.bp_target;
    assign io_o_bp_branch_type = head_entry.bp_branch_type;
    assign io_o_bp_select      = head_entry.bp_select;
    assign io_o_bp_taken       = head_entry.bp_taken;

    // Pointer and occupancy update; flush overrides any enqueue or dequeue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (io_i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_W'(1);
            if (deq) head_d = head_q + PTR_W'(1);
            if (enq && !deq)      count_d = count_q + CNT_W'(1);
            else if (!enq && deq) count_d = count_q - CNT_W'(1);
        end
    end

    // Control state resets asynchronously so the queue reads empty immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage holds data only; validity comes from count, so it needs no reset.
    always_ff @(posedge clock) begin
        if (enq) mem_q[tail_q] <= wr_entry;
    end

endmodule

// File: tb/tb_fetch_res_queue.sv
// tb/tb_fetch_res_queue.sv - scoreboard bench for fetch_res_queue
module tb_fetch_res_queue;

    typedef struct {
        logic [63:0] pc;
        logic [1:0]  valids;
        logic [63:0] insts;
        logic        bpv;
        logic [63:0] target;
        logic [3:0]  btype;
        logic        sel;
        logic        taken;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        a_i_valid, a_i_ready, a_i_stall, a_i_flush;
    logic [63:0] a_i_pc, a_i_fetch_res, a_i_bp_target;
    logic        a_i_bp_valid, a_i_bp_taken;
    logic [3:0]  a_i_bp_branch_type;
    logic [0:0]  a_i_bp_select;
    logic        a_o_valid, a_o_ready;
    logic [63:0] a_o_pc, a_o_insts, a_o_bp_target;
    logic [1:0]  a_o_valids;
    logic        a_o_bp_valid, a_o_bp_taken;
    logic [3:0]  a_o_bp_branch_type;
    logic [0:0]  a_o_bp_select;

    logic         b_i_valid, b_i_ready, b_i_stall, b_i_flush;
    logic [63:0]  b_i_pc, b_i_bp_target;
    logic [127:0] b_i_fetch_res;
    logic         b_i_bp_valid, b_i_bp_taken;
    logic [3:0]   b_i_bp_branch_type;
    logic [1:0]   b_i_bp_select;
    logic         b_o_valid, b_o_ready;
    logic [63:0]  b_o_pc, b_o_bp_target;
    logic [127:0] b_o_insts;
    logic [3:0]   b_o_valids;
    logic         b_o_bp_valid, b_o_bp_taken;
    logic [3:0]   b_o_bp_branch_type;
    logic [1:0]   b_o_bp_select;

    fetch_res_queue #(.XLEN(64), .FETCH_WIDTH(2), .INST_W(32), .DEPTH(4)) dut_a (
        .clock(clock), .reset(reset),
        .io_i_valid(a_i_valid), .io_i_ready(a_i_ready), .io_i_pc(a_i_pc),
        .io_i_fetch_res(a_i_fetch_res), .io_i_stall(a_i_stall), .io_i_flush(a_i_flush),
        .io_i_bp_valid(a_i_bp_valid), .io_i_bp_taken(a_i_bp_taken),
        .io_i_bp_target(a_i_bp_target), .io_i_bp_branch_type(a_i_bp_branch_type),
        .io_i_bp_select(a_i_bp_select),
        .io_o_valid(a_o_valid), .io_o_ready(a_o_ready), .io_o_pc(a_o_pc),
        .io_o_valids(a_o_valids), .io_o_insts(a_o_insts),
        .io_o_bp_valid(a_o_bp_valid), .io_o_bp_target(a_o_bp_target),
        .io_o_bp_branch_type(a_o_bp_branch_type), .io_o_bp_select(a_o_bp_select),
        .io_o_bp_taken(a_o_bp_taken)
    );

    fetch_res_queue #(.XLEN(64), .FETCH_WIDTH(4), .INST_W(32), .DEPTH(4)) dut_b (
        .clock(clock), .reset(reset),
        .io_i_valid(b_i_valid), .io_i_ready(b_i_ready), .io_i_pc(b_i_pc),
        .io_i_fetch_res(b_i_fetch_res), .io_i_stall(b_i_stall), .io_i_flush(b_i_flush),
        .io_i_bp_valid(b_i_bp_valid), .io_i_bp_taken(b_i_bp_taken),
        .io_i_bp_target(b_i_bp_target), .io_i_bp_branch_type(b_i_bp_branch_type),
        .io_i_bp_select(b_i_bp_select),
        .io_o_valid(b_o_valid), .io_o_ready(b_o_ready), .io_o_pc(b_o_pc),
        .io_o_valids(b_o_valids), .io_o_insts(b_o_insts),
        .io_o_bp_valid(b_o_bp_valid), .io_o_bp_target(b_o_bp_target),
        .io_o_bp_branch_type(b_o_bp_branch_type), .io_o_bp_select(b_o_bp_select),
        .io_o_bp_taken(b_o_bp_taken)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference slot mask for a 2-wide block of 32-bit instructions.
    function automatic logic [1:0] exp_mask(input logic [63:0] pc, input logic bpv,
                                            input logic bpt, input logic sel);
        logic [1:0] m;
        m = pc[2] ? 2'b10 : 2'b11;
        if (bpv && bpt && !sel) m = m & 2'b01;
        return m;
    endfunction

    task automatic drive_a(input logic v, input logic [63:0] pc, input logic bpv,
                           input logic bpt, input logic sel);
        a_i_valid          = v;
        a_i_pc             = pc;
        a_i_fetch_res      = {$urandom, $urandom};
        a_i_bp_valid       = bpv;
        a_i_bp_taken       = bpt;
        a_i_bp_select      = sel;
        a_i_bp_target      = pc + 64'h100;
        a_i_bp_branch_type = 4'($urandom_range(0, 15));
    endtask

    // One clock of DUT A: check outputs against the scoreboard, then update the model.
    task automatic tick();
        exp_t       e;
        logic [1:0] m;
        logic       er, eov, enq, deq;
        @(negedge clock);
        er  = (sb.size() < 4) && !a_i_flush;
        eov = (sb.size() != 0) && !a_i_flush;
        chk("i_ready", 128'(a_i_ready), 128'(er));
        chk("o_valid", 128'(a_o_valid), 128'(eov));
        if (eov) begin
            chk("o_pc", 128'(a_o_pc), 128'(sb[0].pc));
            chk("o_valids", 128'(a_o_valids), 128'(sb[0].valids));
            chk("o_insts", 128'(a_o_insts), 128'(sb[0].insts));
            chk("o_bp_valid", 128'(a_o_bp_valid), 128'(sb[0].bpv));
            chk("o_bp_target", 128'(a_o_bp_target), 128'(sb[0].target));
            chk("o_bp_type", 128'(a_o_bp_branch_type), 128'(sb[0].btype));
            chk("o_bp_select", 128'(a_o_bp_select), 128'(sb[0].sel));
            chk("o_bp_taken", 128'(a_o_bp_taken), 128'(sb[0].taken));
        end else begin
            chk("o_valids_idle", 128'(a_o_valids), 128'(0));
        end
        m   = exp_mask(a_i_pc, a_i_bp_valid, a_i_bp_taken, a_i_bp_select[0]);
        deq = eov && a_o_ready;
        enq = a_i_valid && er && !a_i_stall && (m != 2'b00);
        if (a_i_flush) begin
            sb.delete();
        end else begin
            if (deq) void'(sb.pop_front());
            if (enq) begin
                e.pc     = {a_i_pc[63:3], 3'b000};
                e.valids = m;
                e.insts  = a_i_fetch_res;
                e.bpv    = a_i_bp_valid;
                e.target = a_i_bp_target;
                e.btype  = a_i_bp_branch_type;
                e.sel    = a_i_bp_select[0];
                e.taken  = a_i_bp_taken;
                sb.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive_a(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        a_i_stall = 1'b0; a_i_flush = 1'b0; a_o_ready = 1'b1;
        b_i_valid = 1'b0; b_i_stall = 1'b0; b_i_flush = 1'b0; b_o_ready = 1'b1;
        b_i_pc = '0; b_i_fetch_res = '0; b_i_bp_valid = 1'b0; b_i_bp_taken = 1'b0;
        b_i_bp_target = '0; b_i_bp_branch_type = '0; b_i_bp_select = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        tick();

        // Unaligned PC, no prediction.
        drive_a(1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b0);
        tick();
        drive_a(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();

        // Taken branch before the entry slot drops the block; other cut cases.
        drive_a(1'b1, 64'h8000_0004, 1'b1, 1'b1, 1'b0);
        tick();
        drive_a(1'b1, 64'h8000_0000, 1'b1, 1'b1, 1'b0);
        tick();
        drive_a(1'b1, 64'h8000_0008, 1'b1, 1'b1, 1'b1);
        tick();
        drive_a(1'b1, 64'h8000_0010, 1'b1, 1'b0, 1'b0);
        tick();

        // Stall suppresses enqueue.
        a_i_stall = 1'b1;
        drive_a(1'b1, 64'h9000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        a_i_stall = 1'b0;
        drive_a(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();

        // Fill past DEPTH with decode stalled, then drain.
        a_o_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, 64'h2000 + 64'(i * 8), 1'b0, 1'b0, 1'b0);
            tick();
        end
        a_o_ready = 1'b1;
        drive_a(1'b1, 64'h2100, 1'b0, 1'b0, 1'b0);
        tick();
        drive_a(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();

        // Steady concurrent enqueue/dequeue at occupancy 2.
        a_o_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b1, 64'h3000 + 64'(i * 8), 1'b0, 1'b0, 1'b0);
            tick();
        end
        a_o_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_a(1'b1, 64'h3100 + 64'(i * 8) + 64'($urandom_range(0, 1) * 4),
                    1'b0, 1'b0, 1'b0);
            tick();
        end
        drive_a(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        // Flush with a held queue, concurrent valid and ready.
        a_o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 64'h4000 + 64'(i * 8), 1'b0, 1'b0, 1'b0);
            tick();
        end
        a_i_flush = 1'b1; a_o_ready = 1'b1;
        drive_a(1'b1, 64'h4100, 1'b0, 1'b0, 1'b0);
        tick();
        a_i_flush = 1'b0;
        drive_a(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();

        // Asynchronous reset between edges with three entries held.
        a_o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 64'h5000 + 64'(i * 8), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive_a(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("rst_o_valid", 128'(a_o_valid), 128'(0));
        chk("rst_i_ready", 128'(a_i_ready), 128'(1));
        chk("rst_o_valids", 128'(a_o_valids), 128'(0));
        sb.delete();
        @(posedge clock);
        #1 reset = 1'b1;
        a_o_ready = 1'b1;
        tick();
        drive_a(1'b1, 64'h6004, 1'b1, 1'b1, 1'b1);
        tick();
        drive_a(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();

        // Four-wide instance: taken branch trims the tail of the block.
        b_i_valid = 1'b1; b_i_pc = 64'h1000;
        b_i_fetch_res = {$urandom, $urandom, $urandom, $urandom};
        b_i_bp_valid = 1'b1; b_i_bp_taken = 1'b1; b_i_bp_select = 2'd1;
        b_i_bp_target = 64'hDEAD_BEE0; b_i_bp_branch_type = 4'hA;
        @(posedge clock);
        #1 b_i_valid = 1'b0;
        chk("b_o_valid", 128'(b_o_valid), 128'(1));
        chk("b_o_pc", 128'(b_o_pc), 128'(64'h1000));
        chk("b_o_valids", 128'(b_o_valids), 128'(4'b0011));
        chk("b_o_insts", b_o_insts, b_i_fetch_res);
        chk("b_o_bp_valid", 128'(b_o_bp_valid), 128'(1));
        chk("b_o_bp_taken", 128'(b_o_bp_taken), 128'(1));
        chk("b_o_bp_select", 128'(b_o_bp_select), 128'(2'd1));
        chk("b_o_bp_target", 128'(b_o_bp_target), 128'(64'hDEAD_BEE0));
        chk("b_o_bp_type", 128'(b_o_bp_branch_type), 128'(4'hA));
        b_i_valid = 1'b1; b_i_pc = 64'h1008;
        @(posedge clock);
        #1 b_i_valid = 1'b0;
        chk("b_drop_valid", 128'(b_o_valid), 128'(0));
        chk("b_drop_ready", 128'(b_i_ready), 128'(1));
        @(posedge clock);
        #1;
        chk("b_drop_stays", 128'(b_o_valid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_res_queue.md
Name: fetch_res_queue

Overview:
- Parametrised successor to the fetch-result formatter. Turns each aligned fetch block (FETCH_WIDTH instructions) plus its branch-prediction pack into a fetch packet with a per-slot valid mask.
- Buffers packets in a DEPTH-entry FIFO between the I-cache response and decode, with ready/valid on both sides and a single-cycle flush.

Parameters:
- XLEN, 64, PC width.
- FETCH_WIDTH, 2, instructions per fetch block; power of 2, ≥2.
- INST_W, 32, instruction width.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- SEL_W, log2(FETCH_WIDTH), width of the predicted-branch slot index (derived).

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- io_i_valid  in  1  fetch response valid
- io_i_ready  out  1  queue can accept
- io_i_pc  in  XLEN  fetch PC, need not be block-aligned
- io_i_fetch_res  in  FETCH_WIDTH*INST_W  raw block; slot k at bits [k*INST_W +: INST_W]
- io_i_stall  in  1  suppress enqueue this cycle
- io_i_flush  in  1  discard all contents
- io_i_bp_valid / io_i_bp_taken  in  1 each  prediction pack flags
- io_i_bp_target  in  XLEN  predicted target
- io_i_bp_branch_type  in  4  branch type
- io_i_bp_select  in  SEL_W  slot index of the predicted branch
- io_o_valid  out  1  head packet valid
- io_o_ready  in  1  decode accepts
- io_o_pc  out  XLEN  block-aligned PC
- io_o_valids  out  FETCH_WIDTH  per-slot valid mask
- io_o_insts  out  FETCH_WIDTH*INST_W  instructions
- io_o_bp_valid, io_o_bp_target, io_o_bp_branch_type, io_o_bp_select, io_o_bp_taken  out  (as inputs)  prediction pack of head entry

Behaviour:
- OFF = log2(FETCH_WIDTH*INST_W/8) byte-offset bits. Start slot s0 = io_i_pc[OFF-1:2]. Aligned PC = io_i_pc with bits [OFF-1:0] zeroed.
- Slot mask:
  - slot k valid iff k ≥ s0;
  - additionally, if bp_valid & bp_taken, slot k valid only if k ≤ bp_select.
  - If the mask is all-zero (taken select < s0), the packet is accepted and dropped: no entry written, no error.
- Enqueue fires when io_i_valid & io_i_ready & ~io_i_stall & ~io_i_flush and the mask is non-zero.
- io_i_ready = (count < DEPTH) & ~io_i_flush. It is not gated by stall. A full queue does not accept even when a dequeue occurs in the same cycle: no full-bypass.
- io_o_valid = (count != 0) & ~io_i_flush. Outputs are driven from the head entry registers. A dequeue fires on io_o_valid & io_o_ready.
- Latency: an accepted packet is visible at the output on the next rising edge at the earliest. There is no combinational in→out path.
- Pointers:
  - head/tail are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Allowed when 0 < count < DEPTH; when count==0 only enqueue is possible.
- Flush has priority over enqueue and dequeue. Next cycle: head = tail = count = 0. Entry data is don't-care.
- Reset (asynchronous, mid-operation included): head, tail and count clear to 0, so io_o_valid = 0 and io_i_ready = 1 immediately. Entry storage is not reset. Output data while io_o_valid = 0 is don't-care, but io_o_valids must read 0 in that state.
- Control state is count only. The empty/full flags derive from count; no separate FSM.

Decomposition:
- Shared package fetch_pkg holds:
  - XLEN, INST_W, FETCH_WIDTH defaults;
  - the bp_pack struct {valid, target, branch_type[3:0], select, taken};
  - the fetch_packet struct {pc, valids, insts, bp}.
- Sub-module fetch_mask_gen: combinational; computes aligned PC and slot mask from pc/bp. It is reused by the future loop buffer.
- The FIFO stays inline.

Test Plan:
- FETCH_WIDTH=2: pc=0x8000_0004, no prediction, io_o_ready=1 → one cycle later: io_o_pc=0x8000_0000, io_o_valids=2'b10, insts = fetch_res[31:0]/[63:32].
- FETCH_WIDTH=4: pc=0x1000, bp_valid=1, taken=1, select=1 → io_o_valids=4'b0011, bp fields passed unchanged. Repeat with pc=0x1008, select=1 → no entry written, io_o_valid stays 0.
- io_o_ready=0, push 5 packets with DEPTH=4 → io_i_ready drops after the 4th. Drain: packets appear in order with the correct PCs and pointer wrap; io_i_ready is 1 again after the first dequeue.
- Steady concurrent enqueue and dequeue with count=2 for 10 cycles → count stays 2, output order preserved.
- Queue holds 3 entries; assert io_i_flush together with io_i_valid and io_o_ready → io_o_valid=0 that cycle, nothing written. Next cycle count=0 and io_i_ready=1.
- Drop reset low asynchronously between clock edges while count=3 → io_o_valid=0 and io_i_ready=1 before the next edge. After release, the first enqueue appears normally.
